sev_seg_scan: RTL and testbench
===============================

Name: sev_seg_scan

Overview:
- Display back-end for the 8-digit clock/timer face on the Nexys 4 DDR board.
- Consumes the packed 8-digit code word produced by the timer stage and time-multiplexes it onto the shared seven-segment bus.
- Latches a full frame so a mid-frame count update never tears, and inserts a dark guard interval between digits to kill ghosting.

Parameters:
- SCAN_DIV, 100000, clk cycles per digit slot (1 kHz digit rate at 100 MHz); must be >= 2
- GUARD_CYC, 2000, cycles at the start of each slot with all anodes off; 1 <= GUARD_CYC < SCAN_DIV

Ports:
- clk  input  1  board oscillator, 100 MHz (pin E3)
- reset_n  input  1  asynchronous, active-low reset
- digits_i  input  32  digit k code at bits [4k+3:4k]; k=0 is leftmost; codes 0-9 numeral, 10 dash, 11-15 blank
- en  input  1  display enable; 0 forces all anodes off, scanning continues
- out_num  output  7  segments, active-low, bit0=a … bit6=g
- out_dis  output  8  anodes, active-low, bit k drives digit k
- frame_start  output  1  one-cycle pulse when a new frame snapshot is taken

Behaviour:
- Reset (async assert, sync release):
  - out_num=7'h7F, out_dis=8'hFF, frame_start=0
  - prescaler=0, slot index idx=0, snapshot=32'h0, state=BLANK
- Prescaler: counts 0..SCAN_DIV-1 and wraps. The last count is the slot-end tick.
- Slot index idx (3 bits) advances on each slot-end tick and wraps from 7 to 0.
- Frame snapshot:
  - On the tick that wraps idx 7->0, and on the first cycle after reset release, snapshot<=digits_i and frame_start=1 for that cycle.
  - digits_i is ignored at all other times.
- FSM per slot (all outputs registered):
  - BLANK: out_dis=8'hFF; out_num loaded with the decode of snapshot digit idx. Lasts GUARD_CYC cycles (prescaler 0..GUARD_CYC-1).
  - DRIVE: out_dis has only bit idx low, if en=1. Lasts the remaining SCAN_DIV-GUARD_CYC cycles.
  - At the slot-end tick, go to BLANK for the next idx.
- en: sampled every cycle. en=0 gives out_dis=8'hFF on the next cycle. Counters and snapshot are unaffected. Re-asserting en mid-DRIVE lights the current digit on the next cycle.
- Decode (active-low, g..a):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex)
  - 10 (dash)=3F; 11-15=7F
- out_num and out_dis change on the same edge only at BLANK entry, where anodes are off first. No segment change ever occurs while an anode is lit.
- Full frame period = 8*SCAN_DIV cycles. Latency from a digits_i change to display is at most 8*SCAN_DIV+1 cycles.
- Reset mid-slot: outputs return to reset values immediately, without waiting for clk.

Optional Feature:
- Macro: SEV_SEG_LZ_BLANK_EN (leading-zero blanking).
- Defined:
  - A snapshot digit k<7 with code 0 decodes as blank (7F) when every digit j<k also has code 0.
  - The first non-zero code, including dash, ends suppression. Digit 7 is never suppressed.
  - Example: 00-00-05 shows as "  -00-05".
- Undefined: all zeros are displayed. The macro has no port or timing impact.

Decomposition:
- Package sev_seg_pkg holds:
  - localparams CODE_DASH=4'd10 and CODE_BLANK=4'd15
  - SEG_OFF=7'h7F and ANODE_OFF=8'hFF
  - typedef digit_code_t (logic [3:0])
  - function seg_decode(digit_code_t) returning the 7-bit active-low pattern
- One sub-module, sev_seg_decode: combinational code→segment lookup, including the LZ-blank qualifier input. The prescaler, FSM and snapshot stay in sev_seg_scan.

Test Plan (SCAN_DIV=8, GUARD_CYC=2):
- Reset: hold reset_n=0 mid-DRIVE -> out_dis=FF and out_num=7F within the same cycle. After release, frame_start pulses once and digit 0 lights at cycle 2.
- Steady scan: digits_i=0x01A34A56, with digit0 code in bits [3:0] (0x6), so left to right the codes read 6,5,A,4,3,A,1,0.
  - Each slot must show 2 cycles FF, then 6 cycles of the single low anode bit idx, with out_num=02,12,3F,19,30,3F,79,40 in order.
  - Period is 64 cycles.
- Tearing: change digits_i at slot 4 -> the current frame is unchanged, and the new value appears only after the next frame_start.
- Enable: drop en during DRIVE of slot 3 -> out_dis=FF the next cycle. Raise en 3 cycles later -> anode bit 3 is low again on the next cycle, and idx is unaffected.
- Codes 11-15 in all digits -> out_num=7F throughout, while anodes still scan normally.
- With SEV_SEG_LZ_BLANK_EN, 00-00-05 (codes 0,0,A,0,0,A,0,5) -> digits 0,1 give 7F; digit 3 gives 40; digit 7 gives 12. Without the macro, digits 0,1 give 40.

Source files
------------

// File: rtl/sev_seg_pkg.sv
// Shared types, constants and segment lookup for the seven-segment scanner.
// Leading-zero blanking is enabled by defining SEV_SEG_LZ_BLANK_EN.
package sev_seg_pkg;

    localparam logic [3:0] CODE_DASH  = 4'd10;
    localparam logic [3:0] CODE_BLANK = 4'd15;
    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam logic [7:0] ANODE_OFF  = 8'hFF;

    typedef logic [3:0] digit_code_t;

    typedef enum logic {
        BLANK,
        DRIVE
    } scan_state_t;

    // Active-low, bit0=a .. bit6=g
    function automatic logic [6:0] seg_decode(digit_code_t c);
        case (c)
            4'd0:       return 7'h40;
            4'd1:       return 7'h79;
            4'd2:       return 7'h24;
            4'd3:       return 7'h30;
            4'd4:       return 7'h19;
            4'd5:       return 7'h12;
            4'd6:       return 7'h02;
            4'd7:       return 7'h78;
            4'd8:       return 7'h00;
            4'd9:       return 7'h10;
            CODE_DASH:  return 7'h3F;
            CODE_BLANK: return SEG_OFF;
            default:    return SEG_OFF;
        endcase
    endfunction

endpackage

// File: rtl/sev_seg_decode.sv
// Digit code to active-low segment lookup with a forced-blank qualifier.
module sev_seg_decode
    import sev_seg_pkg::*;
(
    input  digit_code_t code,
    input  logic        blank,
    output logic [6:0]  seg
);

    assign seg = blank ? SEG_OFF : seg_decode(code);

endmodule

// File: rtl/sev_seg_scan.sv
// 8-digit multiplexed seven-segment scanner with frame snapshot and guard.
// Define SEV_SEG_LZ_BLANK_EN to suppress leading zeros.
module sev_seg_scan
    import sev_seg_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int GUARD_CYC = 2000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] digits_i,
    input  logic        en,
    output logic [6:0]  out_num,
    output logic [7:0]  out_dis,
    output logic        frame_start
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] GEND = PW'(GUARD_CYC - 1);

    logic [PW-1:0] presc;
    logic [2:0]    idx;
    logic [2:0]    idx_nxt;
    logic [31:0]   snap;
    logic [31:0]   snap_nxt;
    logic          first;
    scan_state_t   state;
    logic          tick;
    logic          guard_end;
    logic          take;
    logic          load_num;
    logic          lz;
    digit_code_t   code_nxt;
    logic [6:0]    seg;

    assign tick      = (presc == LAST);
    assign guard_end = (presc == GEND);
    assign take      = first | (tick & (idx == 3'd7));
    assign idx_nxt   = tick ? idx + 3'd1 : idx;
    assign snap_nxt  = take ? digits_i : snap;
    assign code_nxt  = snap_nxt[{idx_nxt, 2'b00} +: 4];

    // Segments are only reloaded while the anodes are (or go) dark
    assign load_num = first | tick | ((state == BLANK) & ~guard_end);

`ifdef SEV_SEG_LZ_BLANK_EN
    always_comb begin
        lz = (idx_nxt != 3'd7);
        for (int j = 0; j < 7; j++) begin
            if (j <= int'(idx_nxt) && snap_nxt[4*j +: 4] != 4'd0) begin
                lz = 1'b0;
            end
        end
    end
`else
    assign lz = 1'b0;
`endif

    sev_seg_decode u_dec (
        .code  (code_nxt),
        .blank (lz),
        .seg   (seg)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc       <= '0;
            idx         <= '0;
            snap        <= '0;
            first       <= 1'b1;
            state       <= BLANK;
            out_num     <= SEG_OFF;
            out_dis     <= ANODE_OFF;
            frame_start <= 1'b0;
        end else begin
            first       <= 1'b0;
            frame_start <= take;
            snap        <= snap_nxt;
            idx         <= idx_nxt;
            presc       <= tick ? '0 : presc + PW'(1);
            if (load_num) begin
                out_num <= seg;
            end
            if (tick) begin
                state   <= BLANK;
                out_dis <= ANODE_OFF;
            end else if (state == DRIVE || guard_end) begin
                state   <= DRIVE;
                out_dis <= en ? ~(8'd1 << idx) : ANODE_OFF;
            end else begin
                out_dis <= ANODE_OFF;
            end
        end
    end

endmodule

// File: tb/tb_sev_seg_scan.sv
// Self-checking bench for sev_seg_scan (SCAN_DIV=8, GUARD_CYC=2).
// Honours SEV_SEG_LZ_BLANK_EN in its reference model.
module tb_sev_seg_scan;

    localparam int SD = 8;
    localparam int GC = 2;
    localparam int FRAME = 8 * SD;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
    };

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] digits_i;
    logic        en;
    logic [6:0]  out_num;
    logic [7:0]  out_dis;
    logic        frame_start;

    int n_chk  = 0;
    int n_fail = 0;

    int          t;
    int          slot;
    int          ph;
    logic [31:0] m_snap;
    logic [6:0]  exp_num;
    logic [7:0]  exp_dis;
    logic        exp_fs;

    sev_seg_scan #(.SCAN_DIV(SD), .GUARD_CYC(GC)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .digits_i    (digits_i),
        .en          (en),
        .out_num     (out_num),
        .out_dis     (out_dis),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] model_seg(logic [31:0] s, int k);
        logic [3:0]  c;
        logic [31:0] m;
        c = s[4*k +: 4];
        m = 32'((64'd1 << (4 * (k + 1))) - 64'd1);
`ifdef SEV_SEG_LZ_BLANK_EN
        if (k < 7 && (s & m) == 32'd0) return 7'h7F;
`else
        if (m == 32'd0) return 7'h7F;
`endif
        return SEG_TAB[c];
    endfunction

    // Advance one clock and compute what the outputs must now be
    task automatic cyc();
        logic        e_en;
        logic [31:0] e_dig;
        @(posedge clk);
        e_en  = en;
        e_dig = digits_i;
        #1;
        t++;
        if (t == 1 || t % FRAME == 0) m_snap = e_dig;
        slot    = (t / SD) % 8;
        ph      = t % SD;
        exp_fs  = (t == 1 || t % FRAME == 0);
        exp_num = model_seg(m_snap, slot);
        exp_dis = (ph >= GC && e_en) ? ~(8'd1 << slot) : 8'hFF;
    endtask

    function automatic logic [31:0] rand_codes(int lo, int hi);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) v[4*k +: 4] = 4'($urandom_range(hi, lo));
        return v;
    endfunction

    task automatic test_reset();
        reset_n  = 1'b0;
        en       = 1'b1;
        digits_i = 32'h01A34A56;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (out_dis !== 8'hFF || out_num !== 7'h7F || frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: dis=%h num=%h fs=%b want FF 7F 0",
                     out_dis, out_num, frame_start);
        end
        #2 reset_n = 1'b1;
        t = 0;
        cyc();
        n_chk++;
        if (frame_start !== 1'b1 || out_dis !== 8'hFF || out_num !== 7'h02) begin
            n_fail++;
            $display("FAIL reset_first: fs=%b dis=%h num=%h want 1 FF 02",
                     frame_start, out_dis, out_num);
        end
        cyc();
        n_chk++;
        if (frame_start !== 1'b0 || out_dis !== 8'hFE) begin
            n_fail++;
            $display("FAIL reset_light: fs=%b dis=%h want 0 FE",
                     frame_start, out_dis);
        end
        repeat (3) cyc();
        #2 reset_n = 1'b0;
        #1;
        n_chk++;
        if (out_dis !== 8'hFF || out_num !== 7'h7F || frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: dis=%h num=%h fs=%b want FF 7F 0",
                     out_dis, out_num, frame_start);
        end
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        t = 0;
    endtask

    task automatic test_scan(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            cyc();
            n_chk++;
            if (out_dis !== exp_dis || out_num !== exp_num || frame_start !== exp_fs) begin
                n_fail++;
                $display("FAIL scan t=%0d: dis=%h num=%h fs=%b want %h %h %b",
                         t, out_dis, out_num, frame_start, exp_dis, exp_num, exp_fs);
            end
        end
    endtask

    task automatic test_period();
        int first_fs;
        int gap;
        first_fs = -1;
        gap = -1;
        for (int i = 0; i < 2 * FRAME + 2 && gap < 0; i++) begin
            cyc();
            if (frame_start === 1'b1) begin
                if (first_fs < 0) first_fs = t;
                else gap = t - first_fs;
            end
        end
        n_chk++;
        if (gap != FRAME) begin
            n_fail++;
            $display("FAIL period: got %0d want %0d", gap, FRAME);
        end
    endtask

    task automatic test_tearing();
        int guard;
        guard = 0;
        while (slot != 4 && guard < 2 * FRAME) begin
            cyc();
            guard++;
        end
        n_chk++;
        if (slot != 4) begin
            n_fail++;
            $display("FAIL tear_wait: slot=%0d want 4", slot);
        end
        digits_i = rand_codes(0, 10);
        for (int i = 0; i < 2 * FRAME; i++) begin
            cyc();
            n_chk++;
            if (out_num !== exp_num || out_dis !== exp_dis || frame_start !== exp_fs) begin
                n_fail++;
                $display("FAIL tear t=%0d: num=%h dis=%h fs=%b want %h %h %b",
                         t, out_num, out_dis, frame_start, exp_num, exp_dis, exp_fs);
            end
        end
    endtask

    task automatic test_enable();
        int guard;
        guard = 0;
        while (!(slot == 3 && ph == 3) && guard < 2 * FRAME) begin
            cyc();
            guard++;
        end
        en = 1'b0;
        cyc();
        n_chk++;
        if (out_dis !== 8'hFF) begin
            n_fail++;
            $display("FAIL en_drop: dis=%h want FF", out_dis);
        end
        repeat (2) cyc();
        en = 1'b1;
        cyc();
        n_chk++;
        if (out_dis !== 8'hF7 || out_dis !== exp_dis) begin
            n_fail++;
            $display("FAIL en_raise: dis=%h want F7", out_dis);
        end
        test_scan(SD);
    endtask

    task automatic test_random(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            if ($urandom_range(9, 0) == 0) digits_i = $urandom;
            en = ($urandom_range(5, 0) != 0);
            cyc();
            n_chk++;
            if (out_dis !== exp_dis || out_num !== exp_num || frame_start !== exp_fs) begin
                n_fail++;
                $display("FAIL random t=%0d: dis=%h num=%h fs=%b want %h %h %b",
                         t, out_dis, out_num, frame_start, exp_dis, exp_num, exp_fs);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_lz();
        digits_i = 32'h50A00A00;
        test_scan(2 * FRAME);
        digits_i = 32'h00000000;
        test_scan(2 * FRAME);
        digits_i = 32'h0000A000;
        test_scan(2 * FRAME);
    endtask

    initial begin
        test_reset();
        test_scan(2 * FRAME);
        test_period();
        test_tearing();
        test_enable();
        digits_i = rand_codes(11, 15);
        test_scan(2 * FRAME);
        digits_i = rand_codes(0, 9);
        test_scan(2 * FRAME);
        test_random(3 * FRAME);
        test_lz();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
